rob_wb_arb: RTL and testbench
=============================

Name: rob_wb_arb

Overview:
Writeback arbiter between the execution units (branch, LS, EX1, EXMUL1) and the ROB's two result-write ports.
- Each cycle it grants up to two pending unit results, using round-robin priority.
- It registers the granted results onto ROB write port 0 and port 1.
- It backpressures losing units via req_ready; units hold their result until accepted.
- It sits between the EX-stage unit outputs and the ROB store interface.

Parameters:
ROB_DEPTHLOG2, 4, width of ROB slot index
DATA_W, 72, width of packed ROB entry payload (result, dest_reg, dest_reg_valid, pc_valid, ...)
NREQ, 4, number of requesters; index 0=branch, 1=LS, 2=EX1, 3=EXMUL1; fixed at 4 in this revision

Ports:
clock  input  1  single clock
reset_n  input  1  asynchronous, active-low reset
flush  input  1  pipeline flush (mispredict); drops arbitration this cycle
req_valid[4]  input  1 each  unit has a result pending
req_slot[4]  input  ROB_DEPTHLOG2 each  ROB slot of the pending result
req_data[4]  input  DATA_W each  packed ROB entry payload
req_ready[4]  output  1 each  combinational grant; transfer occurs when req_valid & req_ready
wr_valid[2]  output  1 each  registered ROB write enable, per port
wr_slot[2]  output  ROB_DEPTHLOG2 each  registered ROB slot, per port
wr_data[2]  output  DATA_W each  registered payload, per port
rr_ptr_o  output  2  current round-robin start pointer (debug/verification)

Behaviour:
- Reset (async, reset_n=0):
  - wr_valid[*]=0, wr_slot[*]=0, wr_data[*]=0, rr_ptr=0.
  - req_ready[*]=0 while reset_n=0.
- Grant scan (combinational):
  - Walk requesters in order rr_ptr, rr_ptr+1, ... mod 4.
  - The first requester with req_valid=1 gets port 0.
  - The second requester with req_valid=1 gets port 1.
  - At most 2 grants per cycle; req_ready=1 only for granted requesters.
  - req_ready never depends on req_data or req_slot.
- Latency: a result accepted at edge N drives wr_valid/wr_slot/wr_data during cycle N+1, i.e. one register stage.
- Port usage rules:
  - A single grant always uses port 0; port 1 then has wr_valid=0.
  - wr_slot and wr_data of an invalid port hold their previous value; the ROB ignores them.
- Pointer update, at each edge with no flush:
  - 0 grants: rr_ptr unchanged.
  - Otherwise: rr_ptr = (index of last granted requester + 1) mod 4.
  - Wrap: last grant at index 3 gives rr_ptr=0.
- Fairness: any requester holding req_valid=1 is granted within 2 cycles.
- Flush:
  - While flush=1, req_ready[*]=0 (no grants).
  - At the edge sampling flush=1: wr_valid[*] <= 0 and rr_ptr <= 0.
  - Units discard their own pending results on flush; the arbiter holds no result state beyond the output registers.
- Simultaneous events:
  - flush together with valid requests: flush wins and nothing is accepted.
  - More than 2 requesters valid: the losers keep req_valid asserted; the next cycle's scan starts after the last winner.
- Handshake protocol (units):
  - req_valid must stay high, with stable slot/data, until accepted.
  - The arbiter may deassert req_ready without acceptance.
- The ROB write ports never backpressure; wr_valid is asserted for exactly one cycle per accepted result.
- Duplicate slots across ports in the same cycle are a protocol violation by the units; the arbiter does not check for them.
- Reset mid-operation: all outputs clear immediately (async); in-flight wr_valid is lost.

Test Plan:
1. Reset, then req_valid=4'b0100 with slot=5, data=A -> req_ready[2]=1 that cycle. Next cycle wr_valid=[1,0], wr_slot[0]=5, wr_data[0]=A, rr_ptr=3.
2. rr_ptr=0, all 4 valid and held -> cycle 1 grants {0,1} (port0=req0, port1=req1), rr_ptr=2. Cycle 2 grants {2,3}, rr_ptr=0. No requester waits more than 2 cycles.
3. rr_ptr=3, req_valid=4'b1001 -> port0=req3, port1=req0; rr_ptr wraps to 1.
4. flush=1 with req_valid=4'b1111 -> req_ready=0. Next cycle wr_valid=[0,0], rr_ptr=0, even if wr_valid was 1 before the flush.
5. Assert reset_n=0 mid-stream while wr_valid=[1,1] -> wr_valid drops to 0 asynchronously with no clock edge; rr_ptr=0.
6. Random requester valid/hold stress (10k cycles) with scoreboard -> every accepted (slot,data) appears exactly once on a write port one cycle later. No loss, no duplication, max 2 writes per cycle.

Source files
------------

// File: rtl/rob_wb_arb.sv
// rob_wb_arb: round-robin writeback arbiter feeding the two ROB result ports.
// Up to two unit results are granted per cycle and registered onto the ports.
module rob_wb_arb #(
    parameter int ROB_DEPTHLOG2 = 4,
    parameter int DATA_W        = 72,
    parameter int NREQ          = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*ROB_DEPTHLOG2-1:0] req_slot,
    input  logic [NREQ*DATA_W-1:0]        req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [1:0]                    wr_valid,
    output logic [2*ROB_DEPTHLOG2-1:0]    wr_slot,
    output logic [2*DATA_W-1:0]           wr_data,
    output logic [1:0]                    rr_ptr_o
);

    localparam int SW = ROB_DEPTHLOG2;

    logic [SW-1:0]     slot_arr [4];
    logic [DATA_W-1:0] data_arr [4];

    logic [1:0] rr_ptr;
    logic       g0_v;
    logic       g1_v;
    logic [1:0] g0_idx;
    logic [1:0] g1_idx;
    logic [1:0] idx;
    logic [1:0] last_idx;
    logic [1:0] nxt_ptr;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign slot_arr[i] = req_slot[i*SW +: SW];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Scan requesters from rr_ptr; first two valid ones win port 0 and port 1.
    always_comb begin
        g0_v      = 1'b0;
        g1_v      = 1'b0;
        g0_idx    = 2'd0;
        g1_idx    = 2'd0;
        idx       = 2'd0;
        req_ready = '0;
        if (reset_n && !flush) begin
            for (int i = 0; i < 4; i++) begin
                idx = rr_ptr + 2'(i);
                if (req_valid[idx]) begin
                    if (!g0_v) begin
                        g0_v   = 1'b1;
                        g0_idx = idx;
                    end else if (!g1_v) begin
                        g1_v   = 1'b1;
                        g1_idx = idx;
                    end
                end
            end
            if (g0_v) req_ready[g0_idx] = 1'b1;
            if (g1_v) req_ready[g1_idx] = 1'b1;
        end
    end

    assign last_idx = g1_v ? g1_idx : g0_idx;
    assign nxt_ptr  = last_idx + 2'd1;
    assign rr_ptr_o = rr_ptr;

    // Register granted results onto the ROB ports and advance the pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid <= '0;
            wr_slot  <= '0;
            wr_data  <= '0;
            rr_ptr   <= 2'd0;
        end else if (flush) begin
            wr_valid <= '0;
            rr_ptr   <= 2'd0;
        end else begin
            wr_valid <= {g1_v, g0_v};
            if (g0_v) begin
                wr_slot[0 +: SW]     <= slot_arr[g0_idx];
                wr_data[0 +: DATA_W] <= data_arr[g0_idx];
                rr_ptr               <= nxt_ptr;
            end
            if (g1_v) begin
                wr_slot[SW +: SW]         <= slot_arr[g1_idx];
                wr_data[DATA_W +: DATA_W] <= data_arr[g1_idx];
            end
        end
    end

endmodule

// File: tb/tb_rob_wb_arb.sv
// tb_rob_wb_arb: scoreboard bench for rob_wb_arb with a queue-based
// round-robin reference model and randomized unit traffic.
module tb_rob_wb_arb;

    localparam int SW = 4;
    localparam int DW = 72;

    typedef struct {
        int          cyc;
        int          port;
        logic [SW-1:0] slot;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic            clock;
    logic            reset_n;
    logic            flush;
    logic [3:0]      req_valid;
    logic [4*SW-1:0] req_slot;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic [1:0]      wr_valid;
    logic [2*SW-1:0] wr_slot;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      rr_ptr_o;

    rob_wb_arb #(.ROB_DEPTHLOG2(SW), .DATA_W(DW), .NREQ(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_slot  (req_slot),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_valid  (wr_valid),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .rr_ptr_o  (rr_ptr_o)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    wr_exp_t       sb[$];
    logic          pend  [4];
    logic [SW-1:0] pslot [4];
    logic [DW-1:0] pdata [4];
    int            mptr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs(input logic fl);
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = pend[i];
            req_slot[i*SW +: SW]  = pslot[i];
            req_data[i*DW +: DW]  = pdata[i];
        end
        flush = fl;
    endtask

    // One bus cycle: new requests join, then grants are predicted and checked.
    task automatic do_cycle(input logic [3:0] mask, input logic fl);
        int order[$];
        int grants[$];
        logic [3:0] exp_rdy;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && mask[i]) begin
                pend[i]  = 1'b1;
                pslot[i] = SW'($urandom);
                pdata[i] = DW'({$urandom, $urandom, $urandom});
            end
        end
        drive_inputs(fl);
        @(negedge clock);
        chk("rr_ptr", 128'(rr_ptr_o), 128'(mptr));
        order.delete();
        grants.delete();
        for (int k = 0; k < 4; k++)
            if (pend[(mptr + k) % 4]) order.push_back((mptr + k) % 4);
        exp_rdy = 4'b0;
        if (!fl) begin
            for (int k = 0; k < order.size() && k < 2; k++)
                grants.push_back(order[k]);
        end
        foreach (grants[k]) exp_rdy[grants[k]] = 1'b1;
        chk("req_ready", 128'(req_ready), 128'(exp_rdy));
        foreach (grants[k]) begin
            wr_exp_t e;
            e.cyc  = cyc + 1;
            e.port = k;
            e.slot = pslot[grants[k]];
            e.data = pdata[grants[k]];
            sb.push_back(e);
            pend[grants[k]] = 1'b0;
        end
        if (fl) begin
            for (int i = 0; i < 4; i++) pend[i] = 1'b0;
            mptr = 0;
        end else if (grants.size() > 0) begin
            mptr = (grants[grants.size()-1] + 1) % 4;
        end
    endtask

    // Monitor: every asserted write port must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_valid[p]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_wr", 128'(p + 1), 128'(0));
                    end else begin
                        wr_exp_t e;
                        e = sb.pop_front();
                        chk("wr_cycle", 128'(cyc), 128'(e.cyc));
                        chk("wr_port", 128'(p), 128'(e.port));
                        chk("wr_slot", 128'(wr_slot[p*SW +: SW]), 128'(e.slot));
                        chk("wr_data", 128'(wr_data[p*DW +: DW]), 128'(e.data));
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("missing_wr", 128'(sb[0].cyc), 128'(-1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            pend[i]  = 1'b0;
            pslot[i] = '0;
            pdata[i] = '0;
        end
        mptr      = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        req_slot  = '0;
        req_data  = '0;
        #3;
        chk("rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("rst_wr_slot", 128'(wr_slot), 128'(0));
        chk("rst_wr_data", 128'(wr_data), 128'(0));
        chk("rst_rr_ptr", 128'(rr_ptr_o), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        req_valid = 4'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Single grant at index 2, then wrap 3->0, then flush, then full load.
        do_cycle(4'b0100, 1'b0);
        do_cycle(4'b0000, 1'b0);
        do_cycle(4'b1001, 1'b0);
        do_cycle(4'b1111, 1'b1);
        do_cycle(4'b0000, 1'b0);
        do_cycle(4'b1111, 1'b0);
        do_cycle(4'b0000, 1'b0);

        // Async reset while both write ports are busy.
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        drive_inputs(1'b0);
        chk("pre_rst_wr_valid", 128'(wr_valid), 128'(2'b11));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_wr_valid", 128'(wr_valid), 128'(0));
        chk("async_rr_ptr", 128'(rr_ptr_o), 128'(0));
        chk("async_req_ready", 128'(req_ready), 128'(0));
        sb.delete();
        mptr = 0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;

        // Random stress with holding units and occasional flushes.
        for (int n = 0; n < 10000; n++)
            do_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));

        for (int n = 0; n < 4; n++) do_cycle(4'b0000, 1'b0);
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
